// File: rtl/rf_mp.sv
// Multi-ported register file with a per-register pending (scoreboard) bit.
// Define RF_MP_BYPASS_EN to forward same-cycle write data to the read ports.
module rf_mp #(
    parameter int REGISTER_ADDRESS_WIDTH = 5,
    parameter int REGISTER_ADDRESS_DEPTH = 32,
    parameter int DATA_WIDTH             = 32,
    parameter int NUM_READ_PORTS         = 3,
    parameter int NUM_WRITE_PORTS        = 2
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [NUM_WRITE_PORTS-1:0]                   we,
    input  logic [NUM_WRITE_PORTS*REGISTER_ADDRESS_WIDTH-1:0] waddr,
    input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0]        wdata,
    input  logic [NUM_READ_PORTS*REGISTER_ADDRESS_WIDTH-1:0]  raddr,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]         rdata,
    input  logic                                         issue_valid,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0]            issue_rd,
    output logic [NUM_READ_PORTS-1:0]                    rbusy
);
    localparam int AW    = REGISTER_ADDRESS_WIDTH;
    localparam int DW    = DATA_WIDTH;
    localparam int DEPTH = REGISTER_ADDRESS_DEPTH;

    logic [DW-1:0]    regs_q [DEPTH];
    logic [DW-1:0]    regs_d [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

`ifdef RF_MP_BYPASS_EN
    function automatic logic idx_ok(input logic [AW-1:0] a);
        return (a != '0) && (32'(a) < DEPTH);
    endfunction
`endif

    // Index 0 and out-of-range indices never match the r loops, so they are inert.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
            for (int r = 1; r < DEPTH; r++) begin
                if (we[k] && waddr[k*AW +: AW] == AW'(r)) begin
                    regs_d[r] = wdata[k*DW +: DW];
                    pend_d[r] = 1'b0;
                end
            end
        end
        // Issue is applied last so it wins over a same-cycle write clear.
        for (int r = 1; r < DEPTH; r++) begin
            if (issue_valid && issue_rd == AW'(r)) begin
                pend_d[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rd_val;
        logic          rb;
        rdata  = '0;
        rbusy  = '0;
        ra     = '0;
        rd_val = '0;
        rb     = 1'b0;
        for (int i = 0; i < NUM_READ_PORTS; i++) begin
            ra     = raddr[i*AW +: AW];
            rd_val = '0;
            rb     = 1'b0;
            for (int r = 1; r < DEPTH; r++) begin
                if (ra == AW'(r)) begin
                    rd_val = regs_q[r];
                    rb     = pend_q[r];
                end
            end
`ifdef RF_MP_BYPASS_EN
            for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
                if (we[k] && waddr[k*AW +: AW] == ra && idx_ok(ra)) begin
                    rd_val = wdata[k*DW +: DW];
                    rb     = 1'b0;
                end
            end
            if (issue_valid && issue_rd == ra && idx_ok(ra)) begin
                rb = 1'b1;
            end
`endif
            // Outputs are forced quiet while reset is held.
            if (reset) begin
                rd_val = '0;
                rb     = 1'b0;
            end
            rdata[i*DW +: DW] = rd_val;
            rbusy[i]          = rb;
        end
    end
endmodule

// File: doc/rf_mp.md
RF_MP -- requirements
Module: rf_mp

Interface
REQ-001 SHALL have parameter REGISTER_ADDRESS_WIDTH, default 5, register index width.
REQ-002 SHALL have parameter REGISTER_ADDRESS_DEPTH, default 32, number of implemented registers (<= 2**REGISTER_ADDRESS_WIDTH).
REQ-003 SHALL have parameter DATA_WIDTH, default 32, register width.
REQ-004 SHALL have parameter NUM_READ_PORTS, default 3, independent read ports (1..4).
REQ-005 SHALL have parameter NUM_WRITE_PORTS, default 2, independent write ports (1..4).
REQ-006 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port we  input  NUM_WRITE_PORTS  per-port write enable.
REQ-009 SHALL have port waddr  input  NUM_WRITE_PORTS*REGISTER_ADDRESS_WIDTH  packed write indices, port k in slice k.
REQ-010 SHALL have port wdata  input  NUM_WRITE_PORTS*DATA_WIDTH  packed write data.
REQ-011 SHALL have port raddr  input  NUM_READ_PORTS*REGISTER_ADDRESS_WIDTH  packed read indices.
REQ-012 SHALL have port rdata  output  NUM_READ_PORTS*DATA_WIDTH  packed read data.
REQ-013 SHALL have port issue_valid  input  1  instruction issue marking a destination pending.
REQ-014 SHALL have port issue_rd  input  REGISTER_ADDRESS_WIDTH  destination index of issued instruction.
REQ-015 SHALL have port rbusy  output  NUM_READ_PORTS  per-read-port pending (hazard) flag.

Function
REQ-016 Register 0 SHALL read as 0 always; writes and issues to index 0 SHALL be ignored.
REQ-017 Indices >= REGISTER_ADDRESS_DEPTH SHALL read 0, rbusy 0; writes/issues to them ignored.
REQ-018 Reads SHALL be combinational from raddr; zero-cycle latency.
REQ-019 Write with we[k]=1 SHALL update register waddr[k] at the next rising edge (1-cycle latency).
REQ-020 Multiple ports writing the same index in one cycle: highest-numbered port SHALL win.
REQ-021 Scoreboard: one pending bit per register; issue_valid=1 SHALL set pending[issue_rd] at next edge.
REQ-022 Any write (we[k]=1) SHALL clear pending[waddr[k]] at next edge.
REQ-023 Issue and write to the same index in one cycle: set SHALL win (pending=1, data still written).
REQ-024 rbusy[i] SHALL equal pending[raddr[i]], combinational, subject to REQ-016/017 and Configuration.
REQ-025 Issue to an already-pending index SHALL leave it pending (no counting, no error).

Reset
REQ-026 reset=1 at a rising edge SHALL clear all registers and all pending bits; overrides same-cycle writes and issues.
REQ-027 During and after reset rdata SHALL read 0 and rbusy 0 for every port until new writes/issues.
REQ-028 Reset mid-operation SHALL discard in-flight pending state; no write is retained.

Configuration
REQ-029 Macro RF_MP_BYPASS_EN SHALL select same-cycle write-to-read forwarding.
REQ-030 With RF_MP_BYPASS_EN defined: a read whose raddr matches an active write returns that wdata (highest port per REQ-020) and rbusy for that port SHALL be 0 unless issue in the same cycle targets it.
REQ-031 Without RF_MP_BYPASS_EN: reads SHALL return stored value only; new data visible the cycle after the write; rbusy reflects stored pending bits only.

Verification
REQ-032 Reset asserted 2 cycles after writing 0xDEADBEEF to r5 -> next cycle raddr=5 returns 0, rbusy 0.
REQ-033 we=2'b11, waddr={r7,r7}, wdata={0x22 (port1),0x11 (port0)} -> next cycle r7 reads 0x22.
REQ-034 Write 0xFFFF_FFFF to r0 and issue_rd=0 -> r0 reads 0, rbusy 0 on all ports.
REQ-035 issue r9; next cycle raddr=9 -> rbusy=1; write r9=0x55 -> with bypass same-cycle rdata 0x55 rbusy 0, without bypass 0x55/rbusy 0 one cycle later.
REQ-036 Same cycle issue r3 and write r3=0xA5 -> next cycle r3 reads 0xA5, rbusy=1.
REQ-037 REGISTER_ADDRESS_DEPTH=16: write r20=0x1 -> r20 reads 0, no other register changed.
